twp_master: RTL and testbench

TWP_MASTER -- requirements
Module: twp_master

---
 rtl/twp_master.sv | 223 ++++++++++++++++++++++
 tb/tb_twp_master.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/twp_master.sv
// Two-wire protocol master: serialises write/read frames on SDA with SCL as frame-active flag.
// Optional macro TWP_MASTER_TIMEOUT_EN adds a turnaround timeout for reads.
module twp_master #(
   parameter int TAR_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [7:0]  cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_timeout,
   output logic        SCL,
   inout  wire         SDA
);

   typedef enum logic [3:0] {
      IDLE, START, CMD, ADDR, WDATA, STOP, TAR, RDATA, RECOVER
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [7:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rx_q, rx_d;
   logic        seen_q, seen_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_rdata_q, rsp_rdata_d;
   logic        scl_q, scl_d;
   logic        sda_o_q, sda_o_d;
   logic        sda_oe_q, sda_oe_d;
   logic        sda_in;
   logic        to_hit_s;

`ifdef TWP_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TAR_TIMEOUT + 1);
   localparam logic [TW-1:0] TAR_LAST = TW'(TAR_TIMEOUT - 1);
   logic [TW-1:0] tar_cnt_q, tar_cnt_d;
   logic          to_q, to_d;
   logic          rsp_timeout_q, rsp_timeout_d;
   assign to_hit_s    = to_d;
   assign rsp_timeout = rsp_timeout_q;
`else
   assign to_hit_s    = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

   assign sda_in    = SDA;
   assign SDA       = sda_oe_q ? sda_o_q : 1'bz;
   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign SCL       = scl_q;

   // Next-state logic; outputs are derived from the next state so they register in step with it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rx_d    = rx_q;
      seen_d  = seen_q;
`ifdef TWP_MASTER_TIMEOUT_EN
      tar_cnt_d = tar_cnt_q;
      to_d      = to_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               state_d = START;
               write_d = cmd_write;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               cnt_d   = 4'd0;
            end else begin
               state_d = IDLE;
            end
         end
         START: state_d = CMD;
         CMD: begin
            state_d = ADDR;
            cnt_d   = 4'd0;
         end
         ADDR: begin
            if (cnt_q == 4'd7) begin
               cnt_d   = 4'd0;
               state_d = write_q ? WDATA : TAR;
               seen_d  = 1'b0;
`ifdef TWP_MASTER_TIMEOUT_EN
               tar_cnt_d = '0;
               to_d      = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         WDATA: begin
            if (cnt_q == 4'd15) begin
               cnt_d   = 4'd0;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         STOP: state_d = IDLE;
         TAR: begin
            // X/Z on SDA fails both equality tests and is therefore ignored.
            if (seen_q && (sda_in == 1'b0)) begin
               state_d = RDATA;
               cnt_d   = 4'd0;
            end else begin
               if (sda_in == 1'b1) begin
                  seen_d = 1'b1;
               end else begin
                  seen_d = seen_q;
               end
`ifdef TWP_MASTER_TIMEOUT_EN
               if (tar_cnt_q == TAR_LAST) begin
                  state_d = RECOVER;
                  cnt_d   = 4'd0;
                  to_d    = 1'b1;
               end else begin
                  tar_cnt_d = tar_cnt_q + 1'b1;
               end
`endif
            end
         end
         RDATA: begin
            rx_d[cnt_q] = sda_in;
            if (cnt_q == 4'd15) begin
               cnt_d   = 4'd0;
               state_d = RECOVER;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RECOVER: begin
            if (cnt_q == 4'd0) begin
               cnt_d = 4'd1;
            end else begin
               cnt_d   = 4'd0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase

      scl_d       = (state_d != IDLE);
      cmd_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == STOP) || ((state_d == RECOVER) && (cnt_d == 4'd1));
      if ((state_d == RECOVER) && (cnt_d == 4'd1)) begin
         rsp_rdata_d = to_hit_s ? 16'hFFFF : rx_d;
      end else begin
         rsp_rdata_d = rsp_rdata_q;
      end
`ifdef TWP_MASTER_TIMEOUT_EN
      rsp_timeout_d = (state_d == RECOVER) && (cnt_d == 4'd1) && to_d;
`endif
      case (state_d)
         IDLE:    begin sda_oe_d = 1'b1; sda_o_d = 1'b1;               end
         START:   begin sda_oe_d = 1'b1; sda_o_d = 1'b0;               end
         CMD:     begin sda_oe_d = 1'b1; sda_o_d = write_d;            end
         ADDR:    begin sda_oe_d = 1'b1; sda_o_d = addr_d[cnt_d[2:0]]; end
         WDATA:   begin sda_oe_d = 1'b1; sda_o_d = wdata_d[cnt_d];     end
         STOP:    begin sda_oe_d = 1'b1; sda_o_d = 1'b1;               end
         TAR, RDATA, RECOVER: begin sda_oe_d = 1'b0; sda_o_d = 1'b1;  end
         default: begin sda_oe_d = 1'b1; sda_o_d = 1'b1;               end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         write_q     <= 1'b0;
         addr_q      <= 8'h00;
         wdata_q     <= 16'h0000;
         rx_q        <= 16'h0000;
         seen_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 16'h0000;
         scl_q       <= 1'b0;
         sda_o_q     <= 1'b1;
         sda_oe_q    <= 1'b1;
`ifdef TWP_MASTER_TIMEOUT_EN
         tar_cnt_q     <= '0;
         to_q          <= 1'b0;
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rx_q        <= rx_d;
         seen_q      <= seen_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         scl_q       <= scl_d;
         sda_o_q     <= sda_o_d;
         sda_oe_q    <= sda_oe_d;
`ifdef TWP_MASTER_TIMEOUT_EN
         tar_cnt_q     <= tar_cnt_d;
         to_q          <= to_d;
         rsp_timeout_q <= rsp_timeout_d;
`endif
      end
   end

endmodule

// File: tb/tb_twp_master.sv
// Directed bench for twp_master: per-cycle SDA checks plus a response scoreboard.
module tb_twp_master;
   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_write;
   logic [7:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   logic        cmd_ready, rsp_valid, rsp_timeout, scl;
   logic [15:0] rsp_rdata;
   logic        slv_oe = 1'b0;
   logic        slv_bit = 1'b0;
   wire         sda;

   assign sda = slv_oe ? slv_bit : 1'bz;

   typedef struct packed {
      logic [15:0] rdata;
      logic        to;
   } rsp_t;

   rsp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          pulses = 0;
   logic [15:0] last_rdata = 16'h0000;

   twp_master #(.TAR_TIMEOUT(15)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .SCL(scl), .SDA(sda)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rsp_valid === 1'b1) pulses <= pulses + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rsp(input string tag);
      rsp_t e;
      chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_rdata"}, {16'h0, rsp_rdata}, {16'h0, e.rdata});
         chk({tag, "_timeout"}, {31'h0, rsp_timeout}, {31'h0, e.to});
      end
   endtask

   // Called at the negedge of an IDLE cycle; returns at the negedge of the START cycle.
   task automatic issue(input logic w, input logic [7:0] a, input logic [15:0] d, input logic hold);
      chk("cmd_ready_before_issue", {31'h0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      @(negedge clk);
      if (!hold) begin
         cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
      end
   endtask

   task automatic write_frame(input logic [7:0] a, input logic [15:0] d, input int abort_k);
      logic [26:0] bits;
      bits = {1'b1, d, a, 1'b1, 1'b0};
      sb.push_back({last_rdata, 1'b0});
      for (int k = 1; k <= 27; k++) begin
         chk($sformatf("wr_sda_k%0d", k), {31'h0, sda}, {31'h0, bits[k-1]});
         chk("wr_scl", {31'h0, scl}, 32'd1);
         chk($sformatf("wr_rsp_valid_k%0d", k), {31'h0, rsp_valid}, {31'h0, (k == 27)});
         if (rsp_valid === 1'b1) chk_rsp("wr");
         if (k == abort_k) begin
            reset = 1'b1;
            @(negedge clk);
            chk("abort_sda", {31'h0, sda}, 32'd1);
            chk("abort_scl", {31'h0, scl}, 32'd0);
            chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'd0);
            chk("abort_ready", {31'h0, cmd_ready}, 32'd1);
            chk("abort_rdata", {16'h0, rsp_rdata}, 32'h0);
            reset = 1'b0;
            sb.delete();
            last_rdata = 16'h0000;
            return;
         end
         @(negedge clk);
      end
      chk("wr_idle_sda", {31'h0, sda}, 32'd1);
      chk("wr_idle_ready", {31'h0, cmd_ready}, 32'd1);
      chk("wr_idle_scl", {31'h0, scl}, 32'd0);
   endtask

   task automatic send_addr_bits(input logic [7:0] a);
      logic [9:0] bits;
      bits = {a, 1'b0, 1'b0};
      for (int k = 1; k <= 10; k++) begin
         chk($sformatf("rd_sda_k%0d", k), {31'h0, sda}, {31'h0, bits[k-1]});
         @(negedge clk);
      end
   endtask

   // Slave floats for f cycles, drives 1 then 0 (start), 16 data bits LSB first, then a stop 1.
   task automatic read_frame(input logic [7:0] a, input logic [15:0] d, input int f);
      sb.push_back({d, 1'b0});
      send_addr_bits(a);
      for (int k = 11; k <= 30 + f; k++) begin
         if (k < 11 + f)       begin slv_oe = 1'b0; end
         else if (k == 11 + f) begin slv_oe = 1'b1; slv_bit = 1'b1; end
         else if (k == 12 + f) begin slv_oe = 1'b1; slv_bit = 1'b0; end
         else if (k <= 28 + f) begin slv_oe = 1'b1; slv_bit = d[k-13-f]; end
         else if (k == 29 + f) begin slv_oe = 1'b1; slv_bit = 1'b1; end
         else                  begin slv_oe = 1'b0; end
         #1;
         if (k == 11) chk("rd_released", {31'h0, dut.sda_oe_q}, 32'd0);
         if (k == 12 + f) chk("rd_slave_owns_sda", {31'h0, sda}, 32'd0);
         chk($sformatf("rd_rsp_valid_k%0d", k), {31'h0, rsp_valid}, {31'h0, (k == 30 + f)});
         if (rsp_valid === 1'b1) chk_rsp("rd");
         @(negedge clk);
      end
      slv_oe = 1'b0;
      #1;
      chk("rd_idle_sda", {31'h0, sda}, 32'd1);
      chk("rd_idle_ready", {31'h0, cmd_ready}, 32'd1);
      last_rdata = d;
   endtask

   initial begin
      int p0;
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 16'h0000;
      repeat (3) @(negedge clk);
      chk("rst_sda", {31'h0, sda}, 32'd1);
      chk("rst_scl", {31'h0, scl}, 32'd0);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      chk("rst_rsp_timeout", {31'h0, rsp_timeout}, 32'd0);
      chk("rst_rdata", {16'h0, rsp_rdata}, 32'h0);
      chk("rst_ready", {31'h0, cmd_ready}, 32'd1);
      reset = 1'b0;
      @(negedge clk);

      issue(1'b1, 8'h3C, 16'hA5F0, 1'b0); write_frame(8'h3C, 16'hA5F0, 0);
      issue(1'b1, 8'h81, 16'hFFFF, 1'b0); write_frame(8'h81, 16'hFFFF, 0);
      issue(1'b0, 8'h01, 16'h0000, 1'b0); read_frame(8'h01, 16'h1234, 0);
      issue(1'b1, 8'h00, 16'h0000, 1'b0); write_frame(8'h00, 16'h0000, 0);
      issue(1'b0, 8'hC5, 16'h0000, 1'b0); read_frame(8'hC5, 16'hBEEF, 3);
`ifdef TWP_MASTER_TIMEOUT_EN
      issue(1'b0, 8'h7E, 16'h0000, 1'b0);
      sb.push_back({16'hFFFF, 1'b1});
      send_addr_bits(8'h7E);
      for (int k = 11; k <= 27; k++) begin
         chk($sformatf("to_rsp_valid_k%0d", k), {31'h0, rsp_valid}, {31'h0, (k == 27)});
         if (rsp_valid === 1'b1) chk_rsp("to");
         @(negedge clk);
      end
      chk("to_idle_sda", {31'h0, sda}, 32'd1);
      chk("to_idle_ready", {31'h0, cmd_ready}, 32'd1);
      last_rdata = 16'hFFFF;
`else
      issue(1'b0, 8'h7E, 16'h0000, 1'b0); read_frame(8'h7E, 16'h0F0F, 30);
`endif

      // Reset while WDATA bit 5 is on the wire.
      issue(1'b1, 8'h5A, 16'hC3C3, 1'b0); write_frame(8'h5A, 16'hC3C3, 16);
      p0 = pulses;
      repeat (12) @(negedge clk);
      chk("abort_no_pulse", 32'(pulses - p0), 32'd0);
      chk("abort_idle_sda", {31'h0, sda}, 32'd1);
      issue(1'b1, 8'h3C, 16'hA5F0, 1'b0); write_frame(8'h3C, 16'hA5F0, 0);

      // Back-to-back with cmd_valid held; fields change to the second command right after accept.
      issue(1'b1, 8'h12, 16'h3456, 1'b1);
      cmd_addr = 8'hA0; cmd_wdata = 16'h9876;
      write_frame(8'h12, 16'h3456, 0);
      issue(1'b1, 8'hA0, 16'h9876, 1'b0);
      write_frame(8'hA0, 16'h9876, 0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
